// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the commit monitor: FSM encoding,
// default lane count and a saturating adder used by the run counters.
package uarch_pkg;

  localparam int COMMIT_WIDTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2,
    MON_FAIL = 2'd3
  } mon_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// Commit-stage retire bus: one entry per lane, lane 0 oldest.
interface commit_monitor_if
  import uarch_pkg::*;
#(
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEFAULT
) ();

  logic [COMMIT_WIDTH-1:0]        commit_valid;
  logic [COMMIT_WIDTH-1:0]        commit_rd_we;
  logic [COMMIT_WIDTH-1:0][4:0]   commit_rd;
  logic [COMMIT_WIDTH-1:0][31:0]  commit_rd_data;
  logic [COMMIT_WIDTH-1:0][31:0]  commit_pc;

  modport master (
    output commit_valid, commit_rd_we, commit_rd, commit_rd_data, commit_pc
  );

  modport slave (
    input commit_valid, commit_rd_we, commit_rd, commit_rd_data, commit_pc
  );

endinterface

// File: rtl/commit_lane_counter.sv
// Combinational lane filter: counts valid lanes up to and including the
// oldest completion commit; younger lanes behind a completion are masked off.
module commit_lane_counter
  import uarch_pkg::*;
#(
  parameter int          COMMIT_WIDTH = COMMIT_WIDTH_DEFAULT,
  parameter int          CNT_W        = $clog2(COMMIT_WIDTH + 1),
  parameter logic [4:0]  DONE_REG     = 5'd31,
  parameter logic [31:0] DONE_VALUE   = 32'hFF
) (
  input  logic [COMMIT_WIDTH-1:0]       valid,
  input  logic [COMMIT_WIDTH-1:0]       rd_we,
  input  logic [COMMIT_WIDTH-1:0][4:0]  rd,
  input  logic [COMMIT_WIDTH-1:0][31:0] rd_data,
  output logic [COMMIT_WIDTH-1:0]       count_mask,
  output logic [CNT_W-1:0]              count,
  output logic                          done_hit,
  output logic                          any_valid
);

  logic [COMMIT_WIDTH-1:0] is_done;

  genvar gi;
  generate
    for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane
      assign is_done[gi] = valid[gi] & rd_we[gi] &
                           (rd[gi] == DONE_REG) & (rd_data[gi] == DONE_VALUE);
    end
  endgenerate

  always_comb begin
    logic blocked;
    blocked    = 1'b0;
    count_mask = '0;
    count      = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (valid[i] && !blocked) begin
        count_mask[i] = 1'b1;
        count         = count + CNT_W'(1);
        if (is_done[i]) blocked = 1'b1;
      end
    end
  end

  assign done_hit  = |is_done;
  assign any_valid = |valid;

endmodule

// File: rtl/commit_monitor.sv
// Run monitor watching the commit stage: counts cycles, retired instructions
// and stalls, and ends a run on a completion write, cycle limit or deadlock.
module commit_monitor
  import uarch_pkg::*;
#(
  parameter int          COMMIT_WIDTH = COMMIT_WIDTH_DEFAULT,
  parameter int          MAX_CYCLES   = 1000,
  parameter int          STALL_LIMIT  = 64,
  parameter logic [4:0]  DONE_REG     = 5'd31,
  parameter logic [31:0] DONE_VALUE   = 32'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  commit_monitor_if.slave    cif,
  output logic [1:0]         state,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        last_pc,
  output logic [15:0]        max_stall,
  output logic               done,
  output logic               timeout,
  output logic               deadlock
);

  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

  mon_state_e  state_reg;
  logic [31:0] cycle_cnt_reg, instr_cnt_reg, last_pc_reg, stall_cnt_reg;
  logic [15:0] max_stall_reg;
  logic        done_reg, timeout_reg, deadlock_reg;

  logic [COMMIT_WIDTH-1:0] count_mask;
  logic [CNT_W-1:0]        lane_count;
  logic                    done_hit, any_valid;

  commit_lane_counter #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (CNT_W),
    .DONE_REG     (DONE_REG),
    .DONE_VALUE   (DONE_VALUE)
  ) u_lane_counter (
    .valid      (cif.commit_valid),
    .rd_we      (cif.commit_rd_we),
    .rd         (cif.commit_rd),
    .rd_data    (cif.commit_rd_data),
    .count_mask (count_mask),
    .count      (lane_count),
    .done_hit   (done_hit),
    .any_valid  (any_valid)
  );

  logic [31:0] last_pc_next, stall_cnt_next;
  logic [15:0] max_stall_next;
  logic        cycle_limit_hit, stall_limit_hit;

  always_comb begin
    last_pc_next = last_pc_reg;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (count_mask[i]) last_pc_next = cif.commit_pc[i];
    end

    stall_cnt_next = any_valid ? 32'd0 : sat_add32(stall_cnt_reg, 32'd1);
    max_stall_next = max_stall_reg;
    if (stall_cnt_next > {16'd0, max_stall_reg}) begin
      max_stall_next = (stall_cnt_next > 32'h0000_FFFF) ? 16'hFFFF : stall_cnt_next[15:0];
    end

    // Limit checks use the pre-increment cycle count so the run exits with cycle_cnt == MAX_CYCLES.
    cycle_limit_hit = (cycle_cnt_reg == 32'(MAX_CYCLES - 1));
    stall_limit_hit = (stall_cnt_next >= 32'(STALL_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= MON_IDLE;
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
      last_pc_reg   <= '0;
      stall_cnt_reg <= '0;
      max_stall_reg <= '0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      deadlock_reg  <= 1'b0;
    end else begin
      case (state_reg)
        MON_IDLE: begin
          if (start) begin
            state_reg     <= MON_RUN;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
            stall_cnt_reg <= '0;
            max_stall_reg <= '0;
            timeout_reg   <= 1'b0;
            deadlock_reg  <= 1'b0;
          end
        end
        MON_RUN: begin
          cycle_cnt_reg <= sat_add32(cycle_cnt_reg, 32'd1);
          instr_cnt_reg <= sat_add32(instr_cnt_reg, 32'(lane_count));
          last_pc_reg   <= last_pc_next;
          stall_cnt_reg <= stall_cnt_next;
          max_stall_reg <= max_stall_next;
          if (done_hit) begin
            state_reg <= MON_DONE;
            done_reg  <= 1'b1;
          end else if (cycle_limit_hit || stall_limit_hit) begin
            state_reg    <= MON_FAIL;
            timeout_reg  <= timeout_reg | cycle_limit_hit;
            deadlock_reg <= deadlock_reg | stall_limit_hit;
          end
        end
        MON_DONE, MON_FAIL: begin
          if (clear) begin
            state_reg <= MON_IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: state_reg <= MON_IDLE;
      endcase
    end
  end

  assign state     = state_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
  assign last_pc   = last_pc_reg;
  assign max_stall = max_stall_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;
  assign deadlock  = deadlock_reg;

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: a behavioural model queues the expected
// outputs for every driven cycle and they are compared after the clock edge.
module tb_commit_monitor;
  import uarch_pkg::*;

  localparam int W    = 2;
  localparam int MAXC = 1000;
  localparam int STL  = 64;

  logic clk = 1'b0;
  logic rst_n, start, clear;
  always #5 clk = ~clk;

  commit_monitor_if #(.COMMIT_WIDTH(W)) cif ();

  logic [1:0]  state;
  logic [31:0] cycle_cnt, instr_cnt, last_pc;
  logic [15:0] max_stall;
  logic        done, timeout, deadlock;

  commit_monitor #(
    .COMMIT_WIDTH (W),
    .MAX_CYCLES   (MAXC),
    .STALL_LIMIT  (STL),
    .DONE_REG     (5'd31),
    .DONE_VALUE   (32'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .cif       (cif),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt),
    .last_pc   (last_pc),
    .max_stall (max_stall),
    .done      (done),
    .timeout   (timeout),
    .deadlock  (deadlock)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] st, cyc, ins, last, ms, dn, to, dl;
  } exp_t;
  exp_t sbq[$];

  // reference model state
  logic [1:0]  m_st = 2'd0;
  logic [31:0] m_cyc = 0, m_ins = 0, m_last = 0, m_ms = 0, m_stall = 0;
  logic        m_dn = 0, m_to = 0, m_dl = 0;
  logic [31:0] pc_base = 32'h0000_1000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic hit, anyv, tofire;
    if (!rst_n) begin
      m_st = 0; m_cyc = 0; m_ins = 0; m_last = 0; m_ms = 0; m_stall = 0;
      m_dn = 0; m_to = 0; m_dl = 0;
    end else begin
      case (m_st)
        2'd0: if (start) begin
          m_st = 1; m_cyc = 0; m_ins = 0; m_ms = 0; m_stall = 0; m_to = 0; m_dl = 0;
        end
        2'd1: begin
          hit = 0; anyv = 0;
          for (int i = 0; i < W; i++) if (cif.commit_valid[i]) anyv = 1;
          for (int i = 0; i < W; i++) begin
            if (cif.commit_valid[i] && !hit) begin
              if (m_ins != 32'hFFFF_FFFF) m_ins = m_ins + 1;
              m_last = cif.commit_pc[i];
              if (cif.commit_rd_we[i] && cif.commit_rd[i] == 5'd31 && cif.commit_rd_data[i] == 32'hFF)
                hit = 1;
            end
          end
          tofire = (m_cyc == 32'(MAXC - 1));
          if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
          m_stall = anyv ? 0 : m_stall + 1;
          if (m_stall > m_ms) m_ms = (m_stall > 32'd65535) ? 32'd65535 : m_stall;
          if (hit) begin
            m_st = 2; m_dn = 1;
          end else if (tofire || m_stall >= 32'(STL)) begin
            m_st = 3;
            if (tofire) m_to = 1;
            if (m_stall >= 32'(STL)) m_dl = 1;
          end
        end
        default: if (clear) begin
          m_st = 0; m_dn = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.st = 32'(m_st); e.cyc = m_cyc; e.ins = m_ins; e.last = m_last; e.ms = m_ms;
    e.dn = 32'(m_dn); e.to = 32'(m_to); e.dl = 32'(m_dl);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_val("state", 32'(state), e.st);
    check_val("cycle_cnt", cycle_cnt, e.cyc);
    check_val("instr_cnt", instr_cnt, e.ins);
    check_val("last_pc", last_pc, e.last);
    check_val("max_stall", 32'(max_stall), e.ms);
    check_val("done", 32'(done), e.dn);
    check_val("timeout", 32'(timeout), e.to);
    check_val("deadlock", 32'(deadlock), e.dl);
  endtask

  // comp_lane >= 0 forces a completion write on that lane; other lanes may carry
  // near-miss x31=0xFF writes with rd_we low.
  task automatic set_lanes(input logic [W-1:0] v, input int comp_lane);
    int r;
    for (int i = 0; i < W; i++) begin
      cif.commit_valid[i] = v[i];
      cif.commit_pc[i]    = pc_base;
      pc_base             = pc_base + 4;
      r = int'($urandom_range(0, 31));
      if (i == comp_lane) begin
        cif.commit_rd_we[i] = 1'b1; cif.commit_rd[i] = 5'd31; cif.commit_rd_data[i] = 32'hFF;
      end else if (r == 31) begin
        cif.commit_rd_we[i] = 1'b0; cif.commit_rd[i] = 5'd31; cif.commit_rd_data[i] = 32'hFF;
      end else begin
        cif.commit_rd_we[i]   = 1'($urandom_range(0, 1));
        cif.commit_rd[i]      = 5'(r);
        cif.commit_rd_data[i] = $urandom;
      end
    end
  endtask

  task automatic restart();
    clear = 1; set_lanes('0, -1); step(); clear = 0;
    start = 1; step(); start = 0;
  endtask

  logic [31:0] exp_ins, lane0_pc;

  initial begin
    rst_n = 0; start = 0; clear = 0;
    set_lanes('0, -1);
    repeat (2) step();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_instr", instr_cnt, 32'd0);
    $display("reset done");

    rst_n = 1;
    start = 1; step(); start = 0;
    repeat (10) begin set_lanes(2'b11, -1); step(); end
    check_val("dual_instr", instr_cnt, 32'd20);
    check_val("dual_cycle", cycle_cnt, 32'd10);
    check_val("dual_state", 32'(state), 32'd1);
    check_val("dual_stall", 32'(max_stall), 32'd0);
    $display("dual-lane run instr=%0d cycles=%0d", instr_cnt, cycle_cnt);

    // clear and start are both ignored while running
    clear = 1; start = 1; set_lanes(2'b10, -1); step(); clear = 0; start = 0;
    check_val("run_ignore", 32'(state), 32'd1);
    repeat (20) begin set_lanes(W'($urandom_range(0, 3)), -1); step(); end

    exp_ins = m_ins + 1;
    set_lanes(2'b11, 0);
    lane0_pc = cif.commit_pc[0];
    step();
    check_val("l0done_state", 32'(state), 32'd2);
    check_val("l0done_instr", instr_cnt, exp_ins);
    check_val("l0done_pc", last_pc, lane0_pc);
    $display("lane0 completion state=%0d instr=%0d", state, instr_cnt);

    start = 1; set_lanes(2'b11, -1); step(); start = 0;
    check_val("done_ignore", 32'(state), 32'd2);
    check_val("done_hold", instr_cnt, exp_ins);

    clear = 1; set_lanes('0, -1); step(); clear = 0;
    check_val("clr_state", 32'(state), 32'd0);
    check_val("clr_hold", instr_cnt, exp_ins);
    start = 1; step(); start = 0;
    check_val("restart_instr", instr_cnt, 32'd0);
    check_val("restart_cycle", cycle_cnt, 32'd0);
    $display("clear/restart state=%0d", state);

    // completion on the younger lane: both lanes count
    set_lanes(2'b11, 1); step();
    check_val("l1done_instr", instr_cnt, 32'd2);
    check_val("l1done_state", 32'(state), 32'd2);

    restart();
    repeat (MAXC) begin set_lanes(W'($urandom_range(1, 3)), -1); step(); end
    check_val("to_state", 32'(state), 32'd3);
    check_val("to_flag", 32'(timeout), 32'd1);
    check_val("to_cycle", cycle_cnt, 32'd1000);
    $display("cycle limit state=%0d cycles=%0d", state, cycle_cnt);

    restart();
    repeat (MAXC - 1) begin set_lanes(W'($urandom_range(1, 3)), -1); step(); end
    set_lanes(2'b01, 0); step();
    check_val("tolim_state", 32'(state), 32'd2);
    check_val("tolim_flag", 32'(timeout), 32'd0);
    check_val("tolim_cycle", cycle_cnt, 32'd1000);
    $display("completion at limit state=%0d", state);

    restart();
    repeat (5) begin set_lanes(2'b01, -1); step(); end
    set_lanes('0, -1);
    repeat (STL - 1) step();
    check_val("dl_pre_state", 32'(state), 32'd1);
    step();
    check_val("dl_state", 32'(state), 32'd3);
    check_val("dl_flag", 32'(deadlock), 32'd1);
    check_val("dl_stall", 32'(max_stall), 32'd64);
    check_val("dl_instr", instr_cnt, 32'd5);
    $display("stall limit state=%0d max_stall=%0d", state, max_stall);

    restart();
    repeat (50) begin set_lanes(W'($urandom_range(0, 3)), -1); step(); end
    rst_n = 0; step(); rst_n = 1;
    check_val("mrst_state", 32'(state), 32'd0);
    check_val("mrst_cycle", cycle_cnt, 32'd0);
    check_val("mrst_pc", last_pc, 32'd0);
    repeat (5) begin set_lanes(2'b11, -1); step(); end
    check_val("mrst_instr", instr_cnt, 32'd0);
    check_val("mrst_idle", 32'(state), 32'd0);
    $display("mid-run reset state=%0d instr=%0d", state, instr_cnt);

    check_val("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
